// File: rtl/conv3x3_slow_mac.sv
// Serial 3x3 convolution MAC: steps tap index 0..8, accumulates weight*pixel, hands off via valid/ready.
// Optional ReLU on the registered result when CONV3X3_RELU_EN is defined.
module conv3x3_slow_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic [3:0]               cnt,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                state;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   result_load;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    always_comb begin
        prod     = weight * pixel;
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        acc_next = acc + prod_ext;
`ifdef CONV3X3_RELU_EN
        result_load = acc_next[ACC_W-1] ? '0 : acc_next;
`else
        result_load = acc_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        acc   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (cnt == 4'd8) begin
                        // last tap: the result register sees the sum including this product
                        cnt    <= '0;
                        result <= result_load;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == S_MAC) || (state == S_DONE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_conv3x3_slow_mac.sv
// Self-checking bench for conv3x3_slow_mac: randomized windows against a dot-product reference model.
module tb_conv3x3_slow_mac;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     busy;
    logic [3:0]               cnt;
    logic signed [DATA_W-1:0] weight;
    logic signed [DATA_W-1:0] pixel;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [ACC_W-1:0]  result;

    logic signed [DATA_W-1:0] w_arr [16];
    logic signed [DATA_W-1:0] p_arr [16];

    int n_checks = 0;
    int n_fail   = 0;

    conv3x3_slow_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .cnt       (cnt),
        .weight    (weight),
        .pixel     (pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // upstream 9:1 selectors
    assign weight = w_arr[cnt];
    assign pixel  = p_arr[cnt];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model();
        int s = 0;
        for (int i = 0; i < 9; i++)
            s += int'(w_arr[i]) * int'(p_arr[i]);
`ifdef CONV3X3_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic fill_const(input int w, input int p);
        for (int i = 0; i < 16; i++) begin
            w_arr[i] = DATA_W'(w);
            p_arr[i] = DATA_W'(p);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            w_arr[i] = DATA_W'($urandom_range(0, 255));
            p_arr[i] = DATA_W'($urandom_range(0, 255));
        end
    endtask

    // Caller is #1 after an edge in IDLE with start=1 already driven.
    task automatic run_window(input int hold, input bit noise, input bit keep);
        int exp;
        int held;
        exp = model();
        @(posedge clk); #1;
        start     = noise | keep;
        out_ready = noise;
        for (int i = 0; i < 9; i++) begin
            check("mac_cnt", int'(cnt), i);
            check("mac_busy", int'(busy), 1);
            check("mac_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        check("done_valid", int'(out_valid), 1);
        check("done_busy", int'(busy), 1);
        check("done_cnt", int'(cnt), 0);
        check("done_result", int'(result), exp);
        held = int'(result);
        out_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_busy", int'(busy), 1);
            check("bp_result", int'(result), held);
            if (h == hold - 1) out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(out_valid), 0);
        check("idle_cnt", int'(cnt), 0);
        start     = keep;
        out_ready = noise;
    endtask

    initial begin
        fill_const(0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", int'(cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_nostart_busy", int'(busy), 0);

        fill_const(1, 1);
        start = 1'b1;
        run_window(0, 1'b0, 1'b0);
        check("ones_result", int'(result), 9);

        fill_const(-128, -128);
        start = 1'b1;
        run_window(0, 1'b0, 1'b0);
        check("maxpos_result", int'(result), 147456);

        fill_const(127, -128);
        start = 1'b1;
        run_window(1, 1'b0, 1'b0);
`ifdef CONV3X3_RELU_EN
        check("maxneg_result", int'(result), 0);
`else
        check("maxneg_result", int'(result), -146304);
`endif

        // backpressure with start/out_ready noise during busy
        fill_rand();
        start = 1'b1;
        run_window(5, 1'b1, 1'b0);

        // reset mid-window at cnt==4
        fill_const(5, 7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_abort_cnt", int'(cnt), 4);
        rst = 1'b1;
        #1;
        check("abort_cnt", int'(cnt), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_result", int'(result), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_const(2, 3);
        start = 1'b1;
        run_window(0, 1'b0, 1'b0);
        check("post_abort_result", int'(result), 54);

        // back-to-back, start held high
        out_ready = 1'b1;
        start     = 1'b1;
        for (int n = 0; n < 4; n++) begin
            fill_rand();
            run_window(0, 1'b0, n != 3);
        end

        for (int n = 0; n < 20; n++) begin
            fill_rand();
            start = 1'b1;
            run_window(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
